// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
// Op codes, FSM states and the iteration count live here.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } md_state_t;

    localparam int MD_ITER = 32;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One radix-2 iteration on {acc, opq}: shift-add for multiply,
// restoring shift-subtract for divide.
module md_step (
    input  logic        is_div,
    input  logic [31:0] acc,
    input  logic [31:0] opq,
    input  logic [31:0] b,
    output logic [31:0] acc_n,
    output logic [31:0] opq_n
);

    logic [32:0] sum;
    logic [32:0] sh;
    logic [33:0] diff;
    logic        diff_unused;

    assign diff_unused = diff[32];

    always_comb begin
        sum   = {1'b0, acc} + (opq[0] ? {1'b0, b} : 33'd0);
        sh    = {acc, opq[31]};
        diff  = {1'b0, sh} - {2'b00, b};
        acc_n = sum[32:1];
        opq_n = {sum[0], opq[31:1]};
        if (is_div) begin
            // diff[33] is the borrow: remainder too small, keep it
            if (!diff[33]) begin
                acc_n = diff[31:0];
                opq_n = {opq[30:0], 1'b1};
            end else begin
                acc_n = sh[31:0];
                opq_n = {opq[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO and
// pipeline stall generation for dependent ID-stage instructions.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_E,
    input  logic [1:0]  op_E,
    input  logic [31:0] rs_val_E,
    input  logic [31:0] rt_val_E,
    input  logic        hilo_rd_D,
    input  logic        md_op_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        PCEnF,
    output logic        IF_ID_wr,
    output logic        ID_Ex_flush
);

    localparam logic [4:0] CNT_LAST = 5'(MD_ITER - 1);

    md_state_t   state;
    logic [4:0]  cnt;
    logic        div_q;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] acc;
    logic [31:0] opq;
    logic [31:0] dvs;
    logic [31:0] acc_n;
    logic [31:0] opq_n;

    logic        sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] prod;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        stall;

    md_step u_step (
        .is_div (div_q),
        .acc    (acc),
        .opq    (opq),
        .b      (dvs),
        .acc_n  (acc_n),
        .opq_n  (opq_n)
    );

    assign busy  = (state != ST_IDLE);
    assign sgn   = is_signed_op(op_E);
    assign a_mag = (sgn && rs_val_E[31]) ? -rs_val_E : rs_val_E;
    assign b_mag = (sgn && rt_val_E[31]) ? -rt_val_E : rt_val_E;

    // Sign fix: a zero divisor still yields hi = rs, since the
    // remainder magnitude is |rs| and takes the dividend's sign.
    always_comb begin
        prod = neg_q ? -{acc, opq} : {acc, opq};
        q_s  = neg_q ? -opq : opq;
        r_s  = neg_r ? -acc : acc;
        {res_hi, res_lo} = prod;
        if (div_q) begin
            res_hi = r_s;
            res_lo = (dvs == 32'd0) ? 32'hFFFF_FFFF : q_s;
        end
    end

    assign stall       = !rst && (busy || start_E) && (hilo_rd_D || md_op_D);
    assign PCEnF       = !stall;
    assign IF_ID_wr    = !stall;
    assign ID_Ex_flush = stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            acc   <= '0;
            opq   <= '0;
            dvs   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_E) begin
                        div_q <= op_E[1];
                        neg_q <= (sgn && rs_val_E[31]) ^ (sgn && rt_val_E[31]);
                        neg_r <= sgn && rs_val_E[31];
                        acc   <= '0;
                        opq   <= a_mag;
                        dvs   <= b_mag;
                        cnt   <= '0;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc <= acc_n;
                    opq <= opq_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == CNT_LAST) state <= ST_FIX;
                end
                ST_FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    a_no_start_when_busy: assert property (
        @(posedge clk) disable iff (rst) !(busy && start_E)
    );

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, stall and
// reset sequences, and random ops against an arithmetic model.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_E;
    logic [1:0]  op_E;
    logic [31:0] rs_val_E;
    logic [31:0] rt_val_E;
    logic        hilo_rd_D;
    logic        md_op_D;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        PCEnF;
    logic        IF_ID_wr;
    logic        ID_Ex_flush;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start_E     (start_E),
        .op_E        (op_E),
        .rs_val_E    (rs_val_E),
        .rt_val_E    (rt_val_E),
        .hilo_rd_D   (hilo_rd_D),
        .md_op_D     (md_op_D),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .PCEnF       (PCEnF),
        .IF_ID_wr    (IF_ID_wr),
        .ID_Ex_flush (ID_Ex_flush)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural values
    task automatic model(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] ehi,
                         output logic [31:0] elo);
        longint sa, sb, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin p = 64'(sa * sb); {ehi, elo} = p; end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                {ehi, elo} = p;
            end
            2'b10: begin
                if (b == 0) begin ehi = a; elo = '1; end
                else begin
                    r = sa / sb;
                    elo = r[31:0];
                    r = sa % sb;
                    ehi = r[31:0];
                end
            end
            default: begin
                if (b == 0) begin ehi = a; elo = '1; end
                else begin elo = a / b; ehi = a % b; end
            end
        endcase
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic rd, input logic md);
        int stalls;
        int first_done;
        stalls = 0;
        first_done = 0;
        op_E = op;
        rs_val_E = a;
        rt_val_E = b;
        hilo_rd_D = rd;
        md_op_D = md;
        start_E = 1'b1;
        #1;
        if (ID_Ex_flush && !PCEnF && !IF_ID_wr) stalls++;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            start_E = 1'b0;
            #1;
            if (done) begin
                first_done = e;
                break;
            end
            if (ID_Ex_flush && !PCEnF && !IF_ID_wr) stalls++;
            if (e == 17) chk({tag, " hold"}, {hi, lo}, {prev_hi, prev_lo});
        end
        chk({tag, " done_lat"}, 64'(first_done), 64'd34);
        chk({tag, " result"}, {hi, lo}, {ehi, elo});
        if (rd || md) begin
            chk({tag, " stalls"}, 64'(stalls), 64'd34);
            chk({tag, " release"}, {61'd0, ID_Ex_flush, PCEnF, IF_ID_wr},
                64'b011);
        end
        prev_hi = ehi;
        prev_lo = elo;
        hilo_rd_D = 1'b0;
        md_op_D = 1'b0;
        @(posedge clk);
        #2;
        chk({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] ehi, elo, a, b;
        logic [1:0] op;
        int saw_done;

        vecs.push_back('{MD_MULT,  32'hFFFFFFFF, 32'h2,
                         32'hFFFFFFFF, 32'hFFFFFFFE});
        vecs.push_back('{MD_MULTU, 32'hFFFFFFFF, 32'h2,
                         32'h00000001, 32'hFFFFFFFE});
        vecs.push_back('{MD_DIV,   32'hFFFFFFF9, 32'h2,
                         32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{MD_DIVU,  32'd100,      32'h0,
                         32'd100,      32'hFFFFFFFF});
        vecs.push_back('{MD_DIV,   32'd7,        32'hFFFFFFFE,
                         32'd1,        32'hFFFFFFFD});
        vecs.push_back('{MD_DIVU,  32'd100,      32'd7,
                         32'd2,        32'd14});
        vecs.push_back('{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                         32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{MD_MULT,  32'h80000000, 32'h80000000,
                         32'h40000000, 32'h00000000});
        vecs.push_back('{MD_DIV,   32'hFFFFFF9C, 32'h0,
                         32'hFFFFFF9C, 32'hFFFFFFFF});

        rst = 1'b1;
        start_E = 1'b1;
        op_E = '0;
        rs_val_E = '0;
        rt_val_E = '0;
        hilo_rd_D = 1'b1;
        md_op_D = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_flags", {60'd0, busy, done, PCEnF, IF_ID_wr}, 64'b0011);
        chk("rst_flush", 64'(ID_Ex_flush), 64'd0);
        start_E = 1'b0;
        hilo_rd_D = 1'b0;
        md_op_D = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", 64'(busy), 64'd0);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                   vecs[i].b, vecs[i].ehi, vecs[i].elo, 1'b0, 1'b0);

        // MFLO waiting in ID from the start cycle
        run_op("mflo_wait", MD_MULT, 32'hFFFFFFFF, 32'h2,
               32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0);

        // Second MULT stalled in ID, then issued right after release
        run_op("b2b_first", MD_MULTU, 32'h12345678, 32'h9ABCDEF0,
               32'h0B00EA4E, 32'h242D2080, 1'b0, 1'b1);
        run_op("b2b_second", MD_MULT, 32'hFFFFFFFD, 32'd5,
               32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (k % 6 == 5) b = '0;
            else if (k % 3 == 1) b = 32'($urandom_range(1, 300));
            if ($urandom_range(0, 1) == 1) b = -b;
            model(op, a, b, ehi, elo);
            run_op($sformatf("rnd%0d", k), op, a, b, ehi, elo,
                   1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of CALC
        op_E = MD_MULTU;
        rs_val_E = 32'd3;
        rt_val_E = 32'd3;
        start_E = 1'b1;
        @(posedge clk);
        #1;
        start_E = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        saw_done = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #2;
            if (done) saw_done = 1;
        end
        chk("mid_rst_nodone", 64'(saw_done), 64'd0);
        chk("mid_rst_hold", {hi, lo}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 clk  input  1  pipeline clock; all state changes on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start_E  input  1  a MULT/MULTU/DIV/DIVU instruction occupies the EX stage this cycle.
REQ-004 op_E  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 rs_val_E  input  32  forwarded rs operand (multiplicand or dividend).
REQ-006 rt_val_E  input  32  forwarded rt operand (multiplier or divisor).
REQ-007 hilo_rd_D  input  1  the ID-stage instruction reads HI or LO (MFHI/MFLO).
REQ-008 md_op_D  input  1  the ID-stage instruction is a mult or div.
REQ-009 hi  output  32  HI register.
REQ-010 lo  output  32  LO register.
REQ-011 busy  output  1  an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when HI/LO are updated.
REQ-013 PCEnF  output  1  PC write enable; 0 = stall.
REQ-014 IF_ID_wr  output  1  IF/ID write enable; 0 = stall.
REQ-015 ID_Ex_flush  output  1  inserts a bubble into ID/EX.

Function
REQ-016 States are IDLE, CALC and FIX; the state leaves IDLE only on start_E.
- In IDLE, when start_E=1 at edge T, the block SHALL latch the op and operands, clear cnt, and enter CALC.
- The block SHALL stay in CALC for exactly 32 cycles, doing one shift-add or restoring-subtract step per edge.
- cnt is 5 bits and runs 0..31. At cnt=31 the state goes to FIX, with no wrap back into CALC.
- At edge T+33 the block SHALL apply the sign fix, write hi/lo and return to IDLE.
REQ-017 busy SHALL be 1 in every cycle the state is CALC or FIX. done SHALL be 1 only in the cycle after the FIX edge.
REQ-018 A start_E that arrives while busy=1 SHALL be ignored. The stall logic makes this unreachable; assert it in simulation.
REQ-019 Signed ops SHALL run on magnitudes.
- Product sign = sign(rs) XOR sign(rt).
- Quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
- All sign corrections SHALL be done in two's complement in FIX.
REQ-020 MULT/MULTU SHALL produce {hi,lo} = the full 64-bit product.
REQ-021 DIV/DIVU SHALL produce lo = quotient and hi = remainder, truncated toward zero.
REQ-022 When the divisor is 0, the result SHALL be lo = 0xFFFFFFFF and hi = rs_val_E, for both signed and unsigned ops.
REQ-023 stall = (busy OR start_E) AND (hilo_rd_D OR md_op_D). This includes the start cycle itself.
REQ-024 The stall outputs are combinational:
- PCEnF = NOT stall.
- IF_ID_wr = NOT stall.
- ID_Ex_flush = stall.
REQ-025 In the cycle after the FIX edge, stall SHALL be 0 and hi/lo SHALL already hold the new result, so a waiting MFHI/MFLO reads it without forwarding.
REQ-026 hi and lo SHALL change only at the FIX edge or on reset.

Reset
REQ-027 When rst=1 at an edge, the block SHALL return to IDLE from any state, including mid-CALC.
- hi, lo, cnt and the operand/accumulator registers SHALL be cleared to 0.
- busy and done SHALL be 0.
- The partial result SHALL be discarded.
REQ-028 While rst=1, stall SHALL be 0: PCEnF=1, IF_ID_wr=1, ID_Ex_flush=0.

Structure
REQ-029 A shared package SHALL hold:
- the op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
- the state encoding;
- MD_ITER = 32.
REQ-030 The per-iteration arithmetic SHALL be one combinational sub-module, md_step. It performs one shift-add (multiply) or one restore-subtract (divide) step on {acc, operand}.
REQ-031 The FSM, cnt, sign handling, HI/LO registers and stall logic SHALL stay in muldiv_seq.

Verification
REQ-032 MULT rs=0xFFFFFFFF, rt=0x00000002 -> done 34 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-033 MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=100.
REQ-035 MFLO held in ID (hilo_rd_D=1) from the start cycle:
- PCEnF=0, IF_ID_wr=0, ID_Ex_flush=1 for 34 consecutive cycles (start cycle through FIX);
- then stall releases and lo equals the result.
REQ-036 Back-to-back MULT in ID (md_op_D=1) during busy -> stalled until busy falls; the second op starts cleanly and gives its correct product.
REQ-037 rst=1 asserted at cnt=10 -> next cycle busy=0, hi=lo=0, and no done pulse follows.
